// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the MCP4921-class SPI DAC serializer.
// Holds the FSM state encoding, the frame width, the default configuration
// nibble, the bit positions inside the DAC command word and a helper that
// assembles a command word from a sample.
package dac_spi_pkg;

    localparam int FRAME_W    = 16;
    localparam int DAC_DATA_W = 12;

    // Command nibble: A/B=0 (channel A), BUF=1, GA=1 (1x gain), SHDN=1 (active)
    localparam logic [3:0] CFG_BITS_DEFAULT = 4'b0111;

    localparam int BIT_AB   = 15;
    localparam int BIT_BUF  = 14;
    localparam int BIT_GA   = 13;
    localparam int BIT_SHDN = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        LDAC  = 3'd4
    } state_e;

    // SHDN is active-low in the DAC, so a shutdown request clears that bit.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [3:0]            cfg,
        input logic                  shdn_req,
        input logic [DAC_DATA_W-1:0] data
    );
        build_frame = {cfg[3:1], cfg[0] & ~shdn_req, data};
    endfunction

endpackage

// File: rtl/dac_spi_serializer_if.sv
// Pin-level bundle between the serializer and the external DAC.
//   spi_sclk   : SPI clock, idle low (mode 0)
//   spi_mosi   : SPI data, MSB first
//   spi_cs_n   : chip select, active low
//   dac_ldac_n : DAC output latch strobe, active low
// master = serializer side, slave = DAC / observer side.
interface dac_spi_serializer_if;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_cs_n;
    logic dac_ldac_n;

    modport master (output spi_sclk, spi_mosi, spi_cs_n, dac_ldac_n);
    modport slave  (input  spi_sclk, spi_mosi, spi_cs_n, dac_ldac_n);
endinterface

// File: rtl/dac_spi_tick.sv
// Half-period timer for the SPI serializer.
//   clk, rst_n    : system clock, async active-low reset
//   restart_i     : reload the counter (asserted on the cycle before a state entry)
//   phase_tick_o  : high on the last cycle of each SCLK_DIV-cycle phase
// Down-counter with terminal-count compare; it reloads itself on every tick
// so consecutive SCLK half-periods follow without a gap.
module dac_spi_tick #(
    parameter int SCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic phase_tick_o
);
    localparam int            CW     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SCLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign phase_tick_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (restart_i || phase_tick_o) cnt_d = RELOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= RELOAD;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dac_spi_serializer.sv
// Serializes 12-bit samples into 16-bit MCP4921 frames (SPI mode 0, MSB
// first), then pulses LDAC. One sample can wait while a frame is in flight;
// any sample that overwrites or displaces a waiting one is counted as overrun.
//   clk, rst_n     : system clock, async active-low reset
//   sample_en      : one-cycle sample strobe
//   dac_data       : unsigned sample
//   shutdown       : clears the SHDN bit of the frame latched on this edge
//   spi            : SCLK / MOSI / CS_n / LDAC_n pins (master modport)
//   busy           : registered, high whenever the FSM is not IDLE
//   overrun        : one-cycle pulse per discarded sample
//   frame_count    : completed frames, wrapping
//   overrun_count  : discarded samples, saturating at 255
//
// state | meaning
// IDLE  | waiting for a strobe or a pending sample
// SETUP | CS_n low, SCLK low, MOSI = bit 15, one phase
// SHIFT | 16 bits, each a low phase then a high phase of SCLK
// HOLD  | CS_n still low after the last falling SCLK, one phase
// LDAC  | CS_n high, LDAC_n low, one phase
module dac_spi_serializer
    import dac_spi_pkg::*;
#(
    parameter int         DATA_W   = DAC_DATA_W,
    parameter int         SCLK_DIV = 4,
    parameter logic [3:0] CFG_BITS = CFG_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic [DATA_W-1:0]     dac_data,
    input  logic                  shutdown,
    dac_spi_serializer_if.master  spi,
    output logic                  busy,
    output logic                  overrun,
    output logic [15:0]           frame_count,
    output logic [7:0]            overrun_count
);
    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  sr_q, sr_d;
    logic [3:0]          bit_q, bit_d;
    logic                half_q, half_d;
    logic                pend_q, pend_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic                ovr_evt;
    logic                phase_tick;
    logic                restart;

    logic sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, ldac_n_q, ldac_n_d;
    logic busy_q, busy_d, overrun_q;
    logic [15:0] frame_cnt_q;
    logic [7:0]  ovr_cnt_q;

    assign restart = (state_d != state_q);

    dac_spi_tick #(.SCLK_DIV(SCLK_DIV)) u_tick (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart_i    (restart),
        .phase_tick_o (phase_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sample_en || pend_q) state_d = SETUP;
            SETUP:   if (phase_tick) state_d = SHIFT;
            SHIFT:   if (phase_tick && half_q && (bit_q == 4'd0)) state_d = HOLD;
            HOLD:    if (phase_tick) state_d = LDAC;
            LDAC:    if (phase_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: frame latch, pending slot and bit/phase tracking.
    always_comb begin
        sr_d        = sr_q;
        bit_d       = bit_q;
        half_d      = half_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        ovr_evt     = 1'b0;
        if (state_q == IDLE) begin
            if (sample_en) begin
                sr_d    = build_frame(CFG_BITS, shutdown, dac_data);
                ovr_evt = pend_q;
                pend_d  = 1'b0;
            end else if (pend_q) begin
                sr_d   = build_frame(CFG_BITS, shutdown, pend_data_q);
                pend_d = 1'b0;
            end
        end else if (sample_en) begin
            pend_d      = 1'b1;
            pend_data_d = dac_data;
            ovr_evt     = pend_q;
        end
        if ((state_d == SHIFT) && (state_q != SHIFT)) begin
            bit_d  = 4'd15;
            half_d = 1'b0;
        end else if ((state_q == SHIFT) && phase_tick) begin
            half_d = ~half_q;
            // End of the high phase: falling SCLK and next MOSI bit together.
            if (half_q) begin
                sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
                bit_d = bit_q - 4'd1;
            end
        end
    end

    // Pin values are derived from the next state so they register in step with it.
    always_comb begin
        sclk_d   = (state_d == SHIFT) && half_d;
        mosi_d   = ((state_d == SETUP) || (state_d == SHIFT)) ? sr_d[FRAME_W-1] : 1'b0;
        cs_n_d   = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
        ldac_n_d = (state_d != LDAC);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= '0;
            bit_q       <= '0;
            half_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            ldac_n_q    <= 1'b1;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
            ovr_cnt_q   <= '0;
        end else begin
            sr_q        <= sr_d;
            bit_q       <= bit_d;
            half_q      <= half_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            ldac_n_q    <= ldac_n_d;
            busy_q      <= busy_d;
            overrun_q   <= ovr_evt;
            if ((state_q == LDAC) && phase_tick) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (ovr_evt && (ovr_cnt_q != 8'hFF)) ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end

    assign spi.spi_sclk   = sclk_q;
    assign spi.spi_mosi   = mosi_q;
    assign spi.spi_cs_n   = cs_n_q;
    assign spi.dac_ldac_n = ldac_n_q;
    assign busy           = busy_q;
    assign overrun        = overrun_q;
    assign frame_count    = frame_cnt_q;
    assign overrun_count  = ovr_cnt_q;
endmodule

// File: tb/tb_dac_spi_serializer.sv
module tb_dac_spi_serializer;
    import dac_spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic        shutdown = 1'b0;
    logic [11:0] dac_data = 12'h000;
    logic        busy, overrun;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;

    dac_spi_serializer_if spi ();

    dac_spi_serializer #(
        .DATA_W   (12),
        .SCLK_DIV (4),
        .CFG_BITS (4'b0111)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_en     (sample_en),
        .dac_data      (dac_data),
        .shutdown      (shutdown),
        .spi           (spi),
        .busy          (busy),
        .overrun       (overrun),
        .frame_count   (frame_count),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Pin monitor, sampled on the falling clock edge.
    int          cs_run = 0, cs_last = 0, hi_run = 0, gap_last = 0;
    int          ldac_run = 0, ldac_last = 0, ldac_cnt = 0;
    int          busy_run = 0, busy_last = 0, ovr_cnt = 0, nbits = 0;
    logic [15:0] cap = 16'h0000;
    logic        sclk_prev = 1'b0, cs_prev = 1'b1;

    always @(negedge clk) begin
        if (cs_prev && !spi.spi_cs_n) begin
            cap   = 16'h0000;
            nbits = 0;
        end
        if (spi.spi_sclk && !sclk_prev) begin
            cap   = {cap[14:0], spi.spi_mosi};
            nbits = nbits + 1;
        end
        sclk_prev = spi.spi_sclk;
        cs_prev   = spi.spi_cs_n;
        if (!spi.spi_cs_n) begin
            if (hi_run != 0) gap_last = hi_run;
            hi_run = 0;
            cs_run = cs_run + 1;
        end else begin
            if (cs_run != 0) cs_last = cs_run;
            cs_run = 0;
            hi_run = hi_run + 1;
        end
        if (!spi.dac_ldac_n) ldac_run = ldac_run + 1;
        else begin
            if (ldac_run != 0) begin
                ldac_last = ldac_run;
                ldac_cnt  = ldac_cnt + 1;
            end
            ldac_run = 0;
        end
        if (busy) busy_run = busy_run + 1;
        else begin
            if (busy_run != 0) busy_last = busy_run;
            busy_run = 0;
        end
        if (overrun) ovr_cnt = ovr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [11:0] d);
        @(posedge clk); #1;
        dac_data  = d;
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n = 0;
        while (ldac_cnt < target && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({tag, "_frame_done"}, 32'(ldac_cnt >= target), 32'd1);
    endtask

    initial begin
        int base, ov0, n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n",   32'(spi.spi_cs_n),   32'd1);
        chk("rst_sclk",   32'(spi.spi_sclk),   32'd0);
        chk("rst_mosi",   32'(spi.spi_mosi),   32'd0);
        chk("rst_ldac_n", 32'(spi.dac_ldac_n), 32'd1);
        chk("rst_busy",   32'(busy),           32'd0);
        chk("rst_ovr",    32'(overrun),        32'd0);
        chk("rst_fc",     32'(frame_count),    32'd0);
        chk("rst_oc",     32'(overrun_count),  32'd0);
        rst_n = 1'b1;

        // 1: basic frame 0xA5C -> 0x7A5C
        strobe(12'hA5C);
        chk("t1_cs_fall", 32'(spi.spi_cs_n), 32'd0);
        chk("t1_busy",    32'(busy),         32'd1);
        chk("t1_mosi15",  32'(spi.spi_mosi), 32'd0);
        wait_frames(1, "t1");
        chk("t1_word",    32'(cap),          32'h7A5C);
        chk("t1_nbits",   32'(nbits),        32'd16);
        chk("t1_cs_len",  32'(cs_last),      32'd136);
        chk("t1_ldac",    32'(ldac_last),    32'd4);
        chk("t1_busy_len",32'(busy_last),    32'd140);
        chk("t1_fc",      32'(frame_count),  32'd1);
        chk("t1_oc",      32'(overrun_count),32'd0);

        // 2: shutdown clears SHDN
        shutdown = 1'b1;
        strobe(12'hFFF);
        shutdown = 1'b0;
        wait_frames(2, "t2");
        chk("t2_word", 32'(cap),         32'h6FFF);
        chk("t2_fc",   32'(frame_count), 32'd2);

        // 3: overruns while a frame is in flight
        do_reset();
        base = ldac_cnt;
        ov0  = ovr_cnt;
        strobe(12'h100);
        repeat (8) @(posedge clk);
        strobe(12'h200);
        repeat (8) @(posedge clk);
        strobe(12'h300);
        repeat (8) @(posedge clk);
        strobe(12'h400);
        wait_frames(base + 1, "t3a");
        chk("t3_word1",  32'(cap),           32'h7100);
        chk("t3_pulses", 32'(ovr_cnt - ov0), 32'd2);
        chk("t3_oc",     32'(overrun_count), 32'd2);
        wait_frames(base + 2, "t3b");
        chk("t3_word2",  32'(cap),           32'h7400);
        chk("t3_fc",     32'(frame_count),   32'd2);
        chk("t3_gap",    32'(gap_last),      32'd5);

        // 4: reset during SHIFT bit 8 with a pending sample
        do_reset();
        base = ldac_cnt;
        strobe(12'h555);
        repeat (8) @(posedge clk);
        strobe(12'h666);
        repeat (52) @(posedge clk);
        #1;
        chk("t4_nbits_pre", 32'(nbits), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("t4_cs_n",   32'(spi.spi_cs_n),   32'd1);
        chk("t4_sclk",   32'(spi.spi_sclk),   32'd0);
        chk("t4_mosi",   32'(spi.spi_mosi),   32'd0);
        chk("t4_ldac_n", 32'(spi.dac_ldac_n), 32'd1);
        chk("t4_busy",   32'(busy),           32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t4_no_pend_busy", 32'(busy),             32'd0);
        chk("t4_no_ldac",      32'(ldac_cnt - base),  32'd0);
        strobe(12'h123);
        wait_frames(base + 1, "t4");
        chk("t4_word",  32'(cap),         32'h7123);
        chk("t4_nbits", 32'(nbits),       32'd16);
        chk("t4_fc",    32'(frame_count), 32'd1);

        // 5: strobe on the last LDAC cycle becomes pending
        base = ldac_cnt;
        ov0  = ovr_cnt;
        strobe(12'h321);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (spi.dac_ldac_n && n < 300);
        chk("t5_ldac_seen", 32'(spi.dac_ldac_n), 32'd0);
        repeat (2) @(posedge clk);
        strobe(12'h456);
        wait_frames(base + 2, "t5");
        chk("t5_word",   32'(cap),           32'h7456);
        chk("t5_gap",    32'(gap_last),      32'd5);
        chk("t5_no_ovr", 32'(ovr_cnt - ov0), 32'd0);
        chk("t5_oc",     32'(overrun_count), 32'd0);
        chk("t5_fc",     32'(frame_count),   32'd3);

        // 6: sustained strobes saturate the overrun counter
        do_reset();
        base = ldac_cnt;
        ov0  = ovr_cnt;
        for (int i = 0; i < 300; i++) begin
            strobe(12'(i));
            repeat (8) @(posedge clk);
        end
        repeat (400) @(posedge clk);
        #1;
        chk("t6_idle",     32'(busy),                          32'd0);
        chk("t6_oc_sat",   32'(overrun_count),                 32'd255);
        chk("t6_ovr_gt",   32'((ovr_cnt - ov0) > 255),         32'd1);
        chk("t6_fc",       32'(frame_count),                   32'(ldac_cnt - base));
        chk("t6_conserve", 32'((ldac_cnt - base) + (ovr_cnt - ov0)), 32'd300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dac_spi_serializer.md
Name: dac_spi_serializer

Overview:
Downstream output stage of phi_n_neural_processor. Consumes the 12-bit dac_output word on each clk_4khz_en strobe and serializes it to an external MCP4921-class SPI DAC (SPI mode 0, 16-bit frame, MSB first), then pulses LDAC to update the analog output. It holds one pending sample while a frame is in flight and reports samples it drops.

Parameters:
DATA_W, 12, DAC sample width (fixed to the 12-bit DAC).
SCLK_DIV, 4, clk cycles per SCLK half-period; must be >= 1.
CFG_BITS, 4'b0111, frame bits [15:12]: A/B=0, BUF=1, GA=1, SHDN=1.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
sample_en  in  1  single-cycle strobe, driven from clk_4khz_en.
dac_data  in  DATA_W  unsigned sample, driven from dac_output.
shutdown  in  1  when high, the frame SHDN bit (bit 12) is forced to 0.
spi_sclk  out  1  SPI clock, idle low.
spi_mosi  out  1  SPI data.
spi_cs_n  out  1  chip select, active low.
dac_ldac_n  out  1  DAC latch strobe, active low.
busy  out  1  high whenever state != IDLE.
overrun  out  1  one-cycle pulse when a sample is discarded.
frame_count  out  16  completed frames, wraps at 65535 -> 0.
overrun_count  out  8  discarded samples, saturates at 255.

Behaviour:
- Reset (async, asserted): state=IDLE, spi_sclk=0, spi_mosi=0, spi_cs_n=1, dac_ldac_n=1, busy=0, overrun=0, counters=0, pending_valid=0. Any in-flight frame is abandoned with no LDAC pulse.
- All outputs are registered. shutdown is sampled at the same edge the frame word is latched.
- Frame word = {CFG_BITS[3:1], CFG_BITS[0] & ~shutdown, dac_data}.
- IDLE: on sample_en, or when pending_valid=1, latch the word (sample_en wins over pending; the pending sample is then discarded -> overrun). Enter SETUP next cycle.
- SETUP, SCLK_DIV cycles: cs_n=0, sclk=0, mosi=bit15.
- SHIFT, 16 bits x 2*SCLK_DIV cycles. Per bit: SCLK_DIV cycles with sclk=0, then SCLK_DIV cycles with sclk=1. mosi updates only at the sclk 1->0 transition, to the next bit. The DAC samples mosi on the rising edge.
- HOLD, SCLK_DIV cycles: sclk=0, cs_n=0. Then cs_n=1.
- LDAC, SCLK_DIV cycles: dac_ldac_n=0, cs_n=1. On exit: frame_count++ and return to IDLE for at least 1 cycle.
- Timing: cs_n is low for 34*SCLK_DIV cycles and busy is high for 35*SCLK_DIV cycles. cs_n high gap between back-to-back frames = SCLK_DIV+1 cycles.
- sample_en while busy: if pending_valid=0, store the sample with no overrun. If pending_valid=1, overwrite it, pulse overrun on the next cycle, and overrun_count++ (saturating). This includes the last LDAC cycle.
- mosi is 0 outside SETUP/SHIFT. Bit and divider counters are local to the FSM.

Decomposition:
- Package dac_spi_pkg: state encoding (IDLE, SETUP, SHIFT, HOLD, LDAC), FRAME_W=16, default CFG_BITS, MCP4921 bit-position constants.
- One natural sub-module, dac_spi_tick: SCLK_DIV half-period counter emitting a phase_tick, restarted on each state entry.

Test Plan:
1. SCLK_DIV=4, sample_en with dac_data=12'hA5C, shutdown=0 -> cs_n falls 1 cycle after the strobe; 16 rising sclk edges capture 16'h7A5C MSB-first; cs_n low 136 cycles; ldac_n low 4 cycles; busy high 140 cycles; frame_count=1.
2. shutdown=1, dac_data=12'hFFF -> captured word 16'h6FFF.
3. Strobes 0x100 (starts frame), then 0x200, 0x300, 0x400 during that frame -> overrun pulses twice; second frame sends 16'h7400; frame_count=2; overrun_count=2.
4. rst_n asserted during SHIFT bit 8 -> outputs idle immediately, no ldac pulse, pending cleared; next strobe with 0x123 -> clean frame 16'h7123.
5. Strobe on the final LDAC cycle -> stored as pending, no overrun; next frame's cs_n falls exactly 5 cycles after the previous cs_n rise + LDAC start (gap SCLK_DIV+1).
6. 300 strobes every 10 cycles -> overrun_count saturates at 255, and frame_count advances once per completed frame.
